// File: rtl/if_stage_if.sv
// ----------------------------------------------------------------------------
// if_stage_if
//  Fetch port between the IF stage and the shared instruction/data SRAM
//  arbiter. Signal suffixes are relative to the fetch master (IF stage).
//  inst_req_o   master->slave  fetch request
//  inst_addr_o  master->slave  fetch address
//  inst_data_i  slave->master  fetched word, valid with inst_ack_i
//  inst_ack_i   slave->master  fetch complete this cycle
// ----------------------------------------------------------------------------
interface if_stage_if #(
    parameter int ADDR_W = 16,
    parameter int INST_W = 16
);
    logic              inst_req_o;
    logic [ADDR_W-1:0] inst_addr_o;
    logic [INST_W-1:0] inst_data_i;
    logic              inst_ack_i;

    modport master (output inst_req_o, output inst_addr_o,
                    input  inst_data_i, input inst_ack_i);
    modport slave  (input  inst_req_o, input inst_addr_o,
                    output inst_data_i, output inst_ack_i);
endinterface

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
//  Instruction-fetch stage of the 16-bit MIPS16 pipeline. Owns the PC, fetches
//  over a req/ack port, and loads the IF/ID register (pc_o = PC+1, inst_o).
//  Late memory produces NOP bubbles; a fetch completing under stall is parked
//  in hold_buf so it is never re-requested. Branches resolved in decode
//  redirect the PC after the delay-slot instruction is delivered.
//  clk, rst        clock, synchronous active-low reset
//  stall_i         hold IF/ID register and PC
//  branch_flag_i   taken branch from decode (sampled only when not stalled)
//  branch_addr_i   branch target
//  fetch           fetch port (master side)
//  pc_o, inst_o    IF/ID register outputs
// ----------------------------------------------------------------------------
module if_stage #(
    parameter int               ADDR_W   = 16,
    parameter int               INST_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [INST_W-1:0] NOP_INST = 16'h0800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    if_stage_if.master        fetch,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o
);

    typedef enum logic {S_FETCH, S_HOLD} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pco_q, pco_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [INST_W-1:0] hold_q, hold_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              pend_q, pend_d;

    logic              br_take;
    logic              deliver;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] next_pc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            pco_q   <= '0;
            inst_q  <= NOP_INST;
            hold_q  <= NOP_INST;
            tgt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pco_q   <= pco_d;
            inst_q  <= inst_d;
            hold_q  <= hold_d;
            tgt_q   <= tgt_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pco_d   = pco_q;
        inst_d  = inst_q;
        hold_d  = hold_q;
        tgt_d   = tgt_q;
        pend_d  = pend_q;
        deliver = 1'b0;

        // A stalled branch has not left decode yet, so it is not ours to take.
        br_take = branch_flag_i && !stall_i;
        pc_inc  = pc_q + ADDR_W'(1);
        next_pc = br_take ? branch_addr_i : (pend_q ? tgt_q : pc_inc);

        unique case (state_q)
            S_FETCH: begin
                if (fetch.inst_ack_i) begin
                    if (!stall_i) begin
                        deliver = 1'b1;
                        inst_d  = fetch.inst_data_i;
                    end else begin
                        hold_d  = fetch.inst_data_i;
                        state_d = S_HOLD;
                    end
                end else if (!stall_i) begin
                    inst_d = NOP_INST;
                end
            end
            S_HOLD: begin
                if (!stall_i) begin
                    deliver = 1'b1;
                    inst_d  = hold_q;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        // The current fetch is the delay slot: redirect only once it is
        // delivered, remembering the target if the branch comes earlier.
        if (deliver) begin
            pco_d  = pc_inc;
            pc_d   = next_pc;
            pend_d = 1'b0;
        end else if (br_take) begin
            pend_d = 1'b1;
            tgt_d  = branch_addr_i;
        end
    end

    assign fetch.inst_req_o  = rst && (state_q == S_FETCH);
    assign fetch.inst_addr_o = pc_q;
    assign pc_o              = pco_q;
    assign inst_o            = inst_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br;
    logic [15:0] br_addr;
    logic        ack_en;
    logic [15:0] pc_o;
    logic [15:0] inst_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_stage_if #(.ADDR_W(16), .INST_W(16)) fif ();

    // Memory model: word at address a is {4'hE, a[11:0]}.
    assign fif.inst_data_i = {4'hE, fif.inst_addr_o[11:0]};
    assign fif.inst_ack_i  = ack_en;

    if_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall),
        .branch_flag_i(br),
        .branch_addr_i(br_addr),
        .fetch        (fif),
        .pc_o         (pc_o),
        .inst_o       (inst_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [15:0] epc, input logic [15:0] einst);
        chk({tag, ".pc"}, 32'(pc_o), 32'(epc));
        chk({tag, ".inst"}, 32'(inst_o), 32'(einst));
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; br = 1'b0; br_addr = '0; ack_en = 1'b0;
        step(); step();
        chk_ifid("rst", 16'h0000, 16'h0800);
        chk("rst.req", 32'(fif.inst_req_o), 32'd0);
        rst = 1'b1;
        #1;
        chk("rel.req", 32'(fif.inst_req_o), 32'd1);
        chk("rel.addr", 32'(fif.inst_addr_o), 32'h0000);

        // 1: zero-wait streaming
        ack_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t1.addr", 32'(fif.inst_addr_o), 32'(k));
            step();
            chk_ifid("t1", 16'(k + 1), 16'hE000 | 16'(k));
        end

        // 2: two late cycles at 0x0004
        ack_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            chk_ifid("t2.bub", 16'h0004, 16'h0800);
            chk("t2.addr", 32'(fif.inst_addr_o), 32'h0004);
        end
        ack_en = 1'b1;
        step();
        chk_ifid("t2.dlv", 16'h0005, 16'hE004);

        // 3: branch with completing fetch of 0x0005 (delay slot)
        br = 1'b1; br_addr = 16'h0040;
        step();
        br = 1'b0;
        chk_ifid("t3", 16'h0006, 16'hE005);
        chk("t3.addr", 32'(fif.inst_addr_o), 32'h0040);

        // 4: ack under stall parks the word
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4.req", 32'(fif.inst_req_o), 32'd0);
            chk_ifid("t4.hold", 16'h0006, 16'hE005);
        end
        stall = 1'b0; ack_en = 1'b0;
        step();
        chk_ifid("t4.rel", 16'h0041, 16'hE040);
        chk("t4.addr", 32'(fif.inst_addr_o), 32'h0041);
        step();
        chk_ifid("t4.bub", 16'h0041, 16'h0800);
        chk("t4.norefetch", 32'(fif.inst_addr_o), 32'h0041);

        // stall with no ack: nothing moves
        stall = 1'b1;
        step();
        chk_ifid("st.idle", 16'h0041, 16'h0800);
        chk("st.req", 32'(fif.inst_req_o), 32'd1);
        stall = 1'b0;

        // 5: go to 0x0010, then branch while its fetch is outstanding
        ack_en = 1'b1; br = 1'b1; br_addr = 16'h0010;
        step();
        chk_ifid("t5.pre", 16'h0042, 16'hE041);
        ack_en = 1'b0; br_addr = 16'h0100;
        step();
        br = 1'b0;
        chk("t5.addr0", 32'(fif.inst_addr_o), 32'h0010);
        step();
        chk("t5.addr1", 32'(fif.inst_addr_o), 32'h0010);
        ack_en = 1'b1;
        step();
        chk_ifid("t5.slot", 16'h0011, 16'hE010);
        chk("t5.tgt", 32'(fif.inst_addr_o), 32'h0100);
        step();
        chk_ifid("t5.tgtw", 16'h0101, 16'hE100);

        // wrap: fetch at 0xFFFF yields pc_o 0x0000
        br = 1'b1; br_addr = 16'hFFFF;
        step();
        br = 1'b0;
        chk("wr.addr", 32'(fif.inst_addr_o), 32'hFFFF);
        step();
        chk_ifid("wr", 16'h0000, 16'hEFFF);
        chk("wr.next", 32'(fif.inst_addr_o), 32'h0000);

        // 6: reset while waiting at 0x0020, ack pulsed during reset
        br = 1'b1; br_addr = 16'h0020;
        step();
        br = 1'b0; ack_en = 1'b0;
        step();
        chk("t6.wait", 32'(fif.inst_addr_o), 32'h0020);
        rst = 1'b0; ack_en = 1'b1;
        step();
        chk_ifid("t6.rst", 16'h0000, 16'h0800);
        chk("t6.req", 32'(fif.inst_req_o), 32'd0);
        step();
        chk_ifid("t6.rst2", 16'h0000, 16'h0800);
        rst = 1'b1; ack_en = 1'b0;
        #1;
        chk("t6.addr", 32'(fif.inst_addr_o), 32'h0000);
        chk("t6.req1", 32'(fif.inst_req_o), 32'd1);
        ack_en = 1'b1;
        step();
        chk_ifid("t6.first", 16'h0001, 16'hE000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
